// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the execute-stage controller: opcodes, flag bit
// positions, FSM encoding and default sizing.
package alu_exec_ctrl_pkg;

  localparam int NREGS_DEF   = 8;
  localparam int ALU_LAT_DEF = 2;

  localparam logic [7:0] OP_LOAD = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_NOT  = 8'h07;
  localparam logic [7:0] OP_INC  = 8'h08;
  localparam logic [7:0] OP_DEC  = 8'h09;
  localparam logic [7:0] OP_ROL  = 8'h0A;
  localparam logic [7:0] OP_SHL  = 8'h0B;
  localparam logic [7:0] OP_SHR  = 8'h0C;
  localparam logic [7:0] OP_CMP  = 8'h0D;

  localparam int ZF = 0;
  localparam int CF = 1;
  localparam int SF = 2;
  localparam int PF = 3;
  localparam int OF = 6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// NREGS x 8 register file: one write port, three combinational read ports.
module alu_regfile
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] raddr_d,
  output logic [7:0]    rdata_a,
  output logic [7:0]    rdata_b,
  output logic [7:0]    rdata_d
);

  logic [NREGS-1:0][7:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: issues one decoded instruction to the external
// ALU, waits out its latency, then writes back the result and flags.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [7:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          use_imm,
  input  logic [7:0]    imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [7:0]    alu_sel,
  input  logic [7:0]    alu_x,
  input  logic [7:0]    alu_flags,
  output logic [7:0]    flags_q,
  output logic          done,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    rd_q;
  logic             cmp_q;
  logic [7:0]       rs1_data, rs2_data;
  logic             accept, capture;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [7:0]       wdata;

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_WAIT);
  assign accept      = instr_ready && instr_valid;
  assign capture     = busy && (cnt == CNT_W'(ALU_LAT));

  // Loads write at accept, ALU ops at capture; the two never coincide.
  always_comb begin
    we    = 1'b0;
    waddr = rd;
    wdata = imm;
    if (accept && opcode == OP_LOAD) begin
      we = 1'b1;
    end else if (capture && !cmp_q) begin
      we    = 1'b1;
      waddr = rd_q;
      wdata = alu_x;
    end
  end

  alu_regfile #(.NREGS(NREGS), .AW(AW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .raddr_d (dbg_addr),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .rdata_d (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      cmp_q   <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      flags_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          if (opcode == OP_LOAD) begin
            done <= 1'b1;
          end else begin
            alu_a   <= rs1_data;
            alu_b   <= use_imm ? imm : rs2_data;
            alu_sel <= opcode;
            rd_q    <= rd;
            cmp_q   <= (opcode == OP_CMP);
            cnt     <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (capture) begin
            flags_q <= alu_flags;
            alu_sel <= '0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a two-stage registered ALU model.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] opcode = 8'h00;
  logic [2:0] rd = 3'd0, rs1 = 3'd0, rs2 = 3'd0;
  logic       use_imm = 1'b0;
  logic [7:0] imm = 8'h00;
  logic [7:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_x, alu_flags;
  logic [7:0] flags_q;
  logic       done, busy;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .use_imm(use_imm), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_x(alu_x),
    .alu_flags(alu_flags), .flags_q(flags_q), .done(done), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU model: {flags, result}; add/sub/cmp only, anything else returns 0.
  function automatic logic [15:0] alu_f(logic [7:0] s, logic [7:0] a, logic [7:0] b);
    logic [8:0] r;
    logic [7:0] f;
    logic       ov;
    r = '0; f = '0; ov = 1'b0;
    if (s == 8'h01) begin
      r  = {1'b0, a} + {1'b0, b};
      ov = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (s == 8'h02 || s == 8'h0D) begin
      r  = {1'b0, a} - {1'b0, b};
      ov = (a[7] != b[7]) && (r[7] != a[7]);
    end
    if (s == 8'h01 || s == 8'h02 || s == 8'h0D) begin
      f[0] = (r[7:0] == 8'h00);
      f[1] = r[8];
      f[2] = r[7];
      f[3] = ~^r[7:0];
      f[6] = ov;
    end
    return {f, r[7:0]};
  endfunction

  logic [15:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= alu_f(alu_sel, alu_a, alu_b);
    p2 <= p1;
  end
  assign alu_x     = p2[7:0];
  assign alu_flags = p2[15:8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic ui, input logic [7:0] im);
    instr_valid = 1'b1;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = im;
  endtask

  task automatic load(input logic [2:0] d, input logic [7:0] im);
    issue(8'h00, d, 3'd0, 3'd0, 1'b0, im);
    step();
    instr_valid = 1'b0;
    chk("load_done", {7'd0, done}, 8'd1);
  endtask

  initial begin
    // 1: reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_ready", {7'd0, instr_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_flags", flags_q, 8'h00);
    chk("rst_sel", alu_sel, 8'h00);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 8'h00);

    // 2: LOAD, LOAD, ADD r3 = r1 + r2
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    step();
    chk("load_done_clr", {7'd0, done}, 8'd0);
    chk("load_sel_zero", alu_sel, 8'h00);
    chk_reg("r1_load", 3'd1, 8'h05);
    issue(8'h01, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    step();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("add_a", alu_a, 8'h05);
      chk("add_b", alu_b, 8'h03);
      chk("add_sel", alu_sel, 8'h01);
      chk("add_busy", {7'd0, busy}, 8'd1);
      chk("add_no_done", {7'd0, done}, 8'd0);
      step();
    end
    chk("add_done", {7'd0, done}, 8'd1);
    chk("add_ready", {7'd0, instr_ready}, 8'd1);
    chk("add_sel_clr", alu_sel, 8'h00);
    chk("add_flags", flags_q, 8'h00);
    chk_reg("r3_add", 3'd3, 8'h08);
    step();
    chk("add_done_pulse", {7'd0, done}, 8'd0);

    // 3: ADD immediate with signed overflow
    load(3'd1, 8'h7F);
    issue(8'h01, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
    step();
    instr_valid = 1'b0;
    chk("addi_b", alu_b, 8'h01);
    step(); step(); step();
    chk("addi_done", {7'd0, done}, 8'd1);
    chk("addi_flags", flags_q, 8'h44);
    chk_reg("r4_addi", 3'd4, 8'h80);
    chk_reg("r1_keep", 3'd1, 8'h7F);

    // 4: CMP never writes rd; loads leave flags alone
    load(3'd1, 8'h05);
    load(3'd2, 8'h05);
    chk("load_flags_keep", flags_q, 8'h44);
    issue(8'h0D, 3'd1, 3'd1, 3'd2, 1'b0, 8'h00);
    step();
    instr_valid = 1'b0;
    step(); step(); step();
    chk("cmp_done", {7'd0, done}, 8'd1);
    chk("cmp_flags", flags_q, 8'h09);
    chk_reg("r1_cmp", 3'd1, 8'h05);

    // 5: back-to-back ADDs with valid held high; second reads the first's rd
    issue(8'h01, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
    step();
    issue(8'h01, 3'd7, 3'd6, 3'd0, 1'b1, 8'h10);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ready_low", {7'd0, instr_ready}, 8'd0);
      step();
    end
    chk("b2b_done1", {7'd0, done}, 8'd1);
    chk("b2b_ready", {7'd0, instr_ready}, 8'd1);
    chk_reg("r6_b2b", 3'd6, 8'h0A);
    step();
    instr_valid = 1'b0;
    chk("b2b_accept2", {7'd0, busy}, 8'd1);
    chk("b2b_a2", alu_a, 8'h0A);
    chk("b2b_done_clr", {7'd0, done}, 8'd0);
    step(); step();
    chk("b2b_no_early", {7'd0, done}, 8'd0);
    step();
    chk("b2b_done2", {7'd0, done}, 8'd1);
    chk_reg("r7_b2b", 3'd7, 8'h1A);

    // 6: reset during WAIT drops the in-flight SUB
    issue(8'h02, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00);
    step();
    instr_valid = 1'b0;
    step();
    chk("sub_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #2;
    chk("rst_wait_sel", alu_sel, 8'h00);
    chk("rst_wait_busy", {7'd0, busy}, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_no_done", {7'd0, done}, 8'd0);
      step();
    end
    chk("rst_wait_ready", {7'd0, instr_ready}, 8'd1);
    chk_reg("r5_lost", 3'd5, 8'h00);
    chk_reg("r1_cleared", 3'd1, 8'h00);
    chk("rst_wait_flags", flags_q, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
